// File: rtl/writeback_stage.sv
// MiniMIPS WB stage: MEM/WB pipeline register, load alignment/extension and result select.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              LinkM,
  input  logic [1:0]        LoadSizeM,
  input  logic              LoadSignedM,
  input  logic [4:0]        WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [4:0]        WriteRegW,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_W-1:0]  RetireCountW,
`endif
  output logic [DATA_W-1:0] ResultW
);

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              link_q;
  logic [1:0]        load_size_q;
  logic              load_signed_q;
  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] alu_out_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] pc_plus4_q;

  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_data;

  // Flush only needs to kill the control bits; the data fields are don't-care and simply hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      link_q        <= 1'b0;
      load_size_q   <= 2'b00;
      load_signed_q <= 1'b0;
      write_reg_q   <= 5'd0;
      alu_out_q     <= '0;
      read_data_q   <= '0;
      pc_plus4_q    <= '0;
    end else if (FlushW) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!StallW) begin
      valid_q       <= ValidM;
      reg_write_q   <= RegWriteM;
      mem_to_reg_q  <= MemtoRegM;
      link_q        <= LinkM;
      load_size_q   <= LoadSizeM;
      load_signed_q <= LoadSignedM;
      write_reg_q   <= WriteRegM;
      alu_out_q     <= ALUOutM;
      read_data_q   <= ReadDataM;
      pc_plus4_q    <= PCPlus4M;
    end
  end

  always_comb begin
    byte_val  = read_data_q[7:0];
    half_val  = alu_out_q[1] ? read_data_q[31:16] : read_data_q[15:0];
    load_data = read_data_q;
    ResultW   = alu_out_q;
    case (alu_out_q[1:0])
      2'd0:    byte_val = read_data_q[7:0];
      2'd1:    byte_val = read_data_q[15:8];
      2'd2:    byte_val = read_data_q[23:16];
      default: byte_val = read_data_q[31:24];
    endcase
    // Size 11 is reserved and falls through to a plain word load.
    case (load_size_q)
      2'b01:   load_data = {{(DATA_W-16){load_signed_q & half_val[15]}}, half_val};
      2'b10:   load_data = {{(DATA_W-8){load_signed_q & byte_val[7]}}, byte_val};
      default: load_data = read_data_q;
    endcase
    if (link_q)
      ResultW = pc_plus4_q;
    else if (mem_to_reg_q)
      ResultW = load_data;
  end

  assign ValidW    = valid_q;
  assign RegWriteW = reg_write_q & valid_q & (write_reg_q != 5'd0);
  assign WriteRegW = write_reg_q;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the edge it leaves WB unstalled; flush does not un-retire it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      RetireCountW <= '0;
    else if (valid_q && !StallW)
      RetireCountW <= RetireCountW + 1'b1;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table plus stall/flush/reset sequences.
// Counter checks are built only when WB_RETIRE_CNT_EN is defined.
module tb_writeback_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        link;
    logic [1:0]  lsize;
    logic        lsigned;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc;
    logic        exp_valid;
    logic        exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_res;
  } vec_t;

  localparam int NVEC = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallW, FlushW, ValidM, RegWriteM, MemtoRegM, LinkM, LoadSignedM;
  logic [1:0]  LoadSizeM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
  logic        ValidW, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  always #5 CLK = ~CLK;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] RetireCountW;
  logic        ValidW4, RegWriteW4;
  logic [4:0]  WriteRegW4;
  logic [31:0] ResultW4;
  logic [3:0]  RetireCountW4;

  writeback_stage #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM), .LoadSizeM(LoadSizeM),
    .LoadSignedM(LoadSignedM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ValidW(ValidW4), .RegWriteW(RegWriteW4),
    .WriteRegW(WriteRegW4), .RetireCountW(RetireCountW4), .ResultW(ResultW4)
  );
`endif

  writeback_stage #(.DATA_W(32), .CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM), .LoadSizeM(LoadSizeM),
    .LoadSignedM(LoadSignedM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW),
`ifdef WB_RETIRE_CNT_EN
    .RetireCountW(RetireCountW),
`endif
    .ResultW(ResultW)
  );

  task automatic applyStimulus(input vec_t v);
    ValidM      = v.valid;
    RegWriteM   = v.rw;
    MemtoRegM   = v.m2r;
    LinkM       = v.link;
    LoadSizeM   = v.lsize;
    LoadSignedM = v.lsigned;
    WriteRegM   = v.wr;
    ALUOutM     = v.alu;
    ReadDataM   = v.rd;
    PCPlus4M    = v.pc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic rw, input logic [4:0] wr,
                          input logic [31:0] res);
    checkOutput({tag, ".ValidW"}, {31'd0, ValidW}, {31'd0, v});
    checkOutput({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, rw});
    checkOutput({tag, ".WriteRegW"}, {27'd0, WriteRegW}, {27'd0, wr});
    checkOutput({tag, ".ResultW"}, ResultW, res);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t a, b;

    //              v  rw m2r lnk size  sgn wr      alu            rd             pc             ev erw ewr     eres
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd5, 32'h00000123,32'h00000000,32'h00000000,1'b1,1'b1,5'd5, 32'h00000123};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b1,5'd8, 32'h10000002,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd8, 32'hFFFFFFFF};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b0,5'd9, 32'h10000003,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd9, 32'h00000080};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b1,5'd10,32'h10000002,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd10,32'hFFFF80FF};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b1,5'd11,32'h10000003,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd11,32'hFFFF80FF};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,5'd12,32'h10000000,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd12,32'h00007F01};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b1,5'd13,32'h10000001,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd13,32'h0000007F};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b1,5'd14,32'h10000000,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd14,32'h00000001};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,2'b00,1'b1,5'd15,32'h10000004,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd15,32'h80FF7F01};
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,2'b11,1'b1,5'd16,32'h10000002,32'h80FF7F01,32'h00000000,1'b1,1'b1,5'd16,32'h80FF7F01};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b1,2'b00,1'b0,5'd31,32'h00000000,32'hDEADBEEF,32'h00400010,1'b1,1'b1,5'd31,32'h00400010};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd0, 32'h0000BEEF,32'h00000000,32'h00000000,1'b1,1'b0,5'd0, 32'h0000BEEF};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,5'd7, 32'h00000055,32'h00000000,32'h00000000,1'b0,1'b0,5'd7, 32'h00000055};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,5'd9, 32'hCAFE0000,32'h00000000,32'h00000000,1'b1,1'b0,5'd9, 32'hCAFE0000};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,5'd17,32'h20000002,32'h89AB1234,32'h00000000,1'b1,1'b1,5'd17,32'h000089AB};
    vecs[15] = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b1,5'd18,32'h20000003,32'h12345678,32'h00000000,1'b1,1'b1,5'd18,32'h00000012};

    RST = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    applyStimulus('0);
    #1;
    checkAll("reset", 1'b0, 1'b0, 5'd0, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("reset.RetireCountW", RetireCountW, 32'd0);
`endif
    tick(); tick();
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_rw, vecs[i].exp_wr, vecs[i].exp_res);
    end

    // Changing M inputs without an edge must not reach the W outputs
    applyStimulus(vecs[0]);
    #2;
    checkOutput("nocomb.ResultW", ResultW, 32'h00000012);
    tick();

    // Stall for three cycles: W holds A while M presents B
    a = vecs[3];
    b = vecs[0];
    applyStimulus(a);
    tick();
    StallW = 1'b1;
    applyStimulus(b);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd10, 32'hFFFF80FF);
    end
    StallW = 1'b0;
    tick();
    checkAll("unstall", 1'b1, 1'b1, 5'd5, 32'h00000123);

    // Flush together with stall: flush wins
    applyStimulus(vecs[1]);
    tick();
    FlushW = 1'b1; StallW = 1'b1;
    tick();
    checkOutput("flushstall.ValidW", {31'd0, ValidW}, 32'd0);
    checkOutput("flushstall.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    FlushW = 1'b0; StallW = 1'b0;
    tick();
    checkAll("afterflush", 1'b1, 1'b1, 5'd8, 32'hFFFFFFFF);

    // Asynchronous reset pulse mid-cycle
    applyStimulus(vecs[10]);
    tick();
    checkAll("prereset", 1'b1, 1'b1, 5'd31, 32'h00400010);
    #2 RST = 1'b1;
    #1;
    checkAll("asyncreset", 1'b0, 1'b0, 5'd0, 32'h0);
    #1 RST = 1'b0;
    tick();
    checkAll("postreset", 1'b1, 1'b1, 5'd31, 32'h00400010);

`ifdef WB_RETIRE_CNT_EN
    RST = 1'b1;
    #1 RST = 1'b0;
    checkOutput("cnt.reset", RetireCountW, 32'd0);
    applyStimulus(vecs[0]);
    for (int i = 0; i < 4; i++) tick();
    FlushW = 1'b1;
    tick();
    FlushW = 1'b0; StallW = 1'b1;
    tick(); tick();
    StallW = 1'b0;
    checkOutput("cnt.flushstall", RetireCountW, 32'd4);

    RST = 1'b1;
    #1 RST = 1'b0;
    applyStimulus(vecs[0]);
    for (int i = 0; i < 18; i++) tick();
    checkOutput("cnt.seventeen", RetireCountW, 32'd17);
    checkOutput("cnt4.wrap", {28'd0, RetireCountW4}, 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("cnt.asyncreset", RetireCountW, 32'd0);
    checkOutput("cnt4.asyncreset", {28'd0, RetireCountW4}, 32'd0);
    RST = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (WB) stage of the 5-stage MiniMIPS pipeline. It registers the MEM-stage results in the MEM/WB pipeline register and aligns and extends load data. It selects the value written back to the register file and drives the register-file write port (`RegWriteW`, `WriteRegW`, `ResultW`), which the decode stage reads from. An optional retired-instruction counter is included.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; only 32 is supported.
- `CNT_W`, 32: retire counter width.

Ports:
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `StallW`  in  1: hold the MEM/WB register.
- `FlushW`  in  1: load a bubble into the MEM/WB register.
- `ValidM`  in  1: MEM stage holds a real instruction.
- `RegWriteM`  in  1: the instruction writes a register.
- `MemtoRegM`  in  1: the result comes from memory.
- `LinkM`  in  1: the result is `PCPlus4M` (JAL).
- `LoadSizeM`  in  2: 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word).
- `LoadSignedM`  in  1: sign-extend sub-word loads.
- `WriteRegM`  in  5: destination register.
- `ALUOutM`  in  32: ALU result / effective address.
- `ReadDataM`  in  32: data memory read word.
- `PCPlus4M`  in  32: link value.
- `ValidW`  out  1: WB holds a real instruction.
- `RegWriteW`  out  1: register-file write enable.
- `WriteRegW`  out  5: register-file write address.
- `ResultW`  out  32: register-file write data.
- `RetireCountW`  out  `CNT_W`: retired-instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- The MEM/WB register captures `ValidM`, `RegWriteM`, `MemtoRegM`, `LinkM`, `LoadSizeM`, `LoadSignedM`, `WriteRegM`, `ALUOutM`, `ReadDataM` and `PCPlus4M`.
- Register update priority, per rising edge:
  - `RST`: all fields 0.
  - `FlushW`: `Valid` = 0 and `RegWrite` = 0; other fields are don't-care (held).
  - `StallW`: hold all fields.
  - Otherwise: load from the M-stage inputs.
- `RegWriteW` = `RegWrite_q & Valid_q & (WriteReg_q != 0)`. Writes to $0 are suppressed here.
- Load alignment uses byte offset `off` = `ALUOut_q[1:0]`:
  - Word: `ReadData_q` unchanged.
  - Half: `off[1]`=0 selects bits [15:0], 1 selects bits [31:16]. `off[0]` is ignored.
  - Byte: selects `ReadData_q[8*off+7 : 8*off]`.
  - Sub-word values are zero-extended, or sign-extended when `LoadSigned_q`=1.
- Result select priority:
  - `Link_q` gives `PCPlus4_q`.
  - Else `MemtoReg_q` gives the aligned load data.
  - Else `ResultW` = `ALUOut_q`.
- `WriteRegW` = `WriteReg_q`, driven even when `RegWriteW`=0.

## Timing
- Latency: M-stage inputs are visible on the W outputs 1 cycle after the capturing edge.
- `ResultW`, `RegWriteW` and `WriteRegW` are combinational from the MEM/WB register only; there is no combinational path from any M input.
- Reset values: `ValidW`=0, `RegWriteW`=0, `WriteRegW`=0, `ResultW`=0, `RetireCountW`=0.
- Reset asserted mid-instruction clears the instruction immediately and asynchronously; the write enable drops the same cycle.
- `FlushW` and `StallW` asserted together: the flush wins.
- The register file samples `RegWriteW`/`WriteRegW`/`ResultW` on the same edge. The decode stage relies on write-before-read in the register file; this block adds no bypass.
- While `StallW`=1, `RegWriteW` stays asserted if it was set. A repeated write of the same value is harmless.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `RetireCountW` exists.
  - It increments by 1 on each rising edge where `ValidW`=1 and `StallW`=0.
  - It wraps from 2^`CNT_W`-1 to 0 and is cleared by `RST` only. `FlushW` does not affect it.
- Not defined: the port and the counter logic are absent, and the remaining behaviour is identical.

## Test plan
- Reset, then an R-type instruction: `ALUOutM`=0x00000123, `WriteRegM`=5, `RegWriteM`=1 → next cycle `RegWriteW`=1, `WriteRegW`=5, `ResultW`=0x00000123.
- LB sign: `ReadDataM`=0x80FF7F01, `ALUOutM`=...02, byte load, signed → `ResultW`=0xFFFFFFFF. Unsigned with offset 3 → 0x00000080. LH signed with offset 2 → 0xFFFF80FF.
- JAL with `PCPlus4M`=0x00400010, `WriteRegM`=31, and `MemtoRegM`=1 also set → `ResultW`=0x00400010 (link wins).
- `WriteRegM`=0 with `RegWriteM`=1 → `RegWriteW`=0. `StallW`=1 for 3 cycles → W outputs are held. `FlushW`=`StallW`=1 → `ValidW`=0, `RegWriteW`=0.
- With `WB_RETIRE_CNT_EN`: 4 valid instructions, then 1 flushed, then 2 stalled cycles → `RetireCountW`=4. With `CNT_W`=4, 17 retirements → `RetireCountW`=1. Async `RST` pulse mid-cycle → all outputs 0 before the next edge.
